// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
// truth_table_sweeper_pkg : shared state encoding and width helpers
// Rev 1.0
// ============================================================================
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // Truth-table width (2^n) and error-counter width (n+1) for an n-input function
  function automatic int tt_bits(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_bits(input int n);
    return n + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_counter.sv
`default_nettype none
// ============================================================================
// truth_table_sweeper_counter : input-vector index plus per-vector settle timer
// Rev 1.0
// ============================================================================
module truth_table_sweeper_counter #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  output logic [N_IN-1:0] idx,
  output logic            settle_done,
  output logic            last
);

  localparam int              SW            = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   C_SETTLE_INIT = SW'(SETTLE - 1);

  logic [N_IN-1:0] r_idx;
  logic [SW-1:0]   r_settle;

  // Settle timer reloads with every new index and counts down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_settle <= '0;
    end else if (load) begin
      r_idx    <= '0;
      r_settle <= C_SETTLE_INIT;
    end else if (step) begin
      r_idx    <= r_idx + N_IN'(1);
      r_settle <= C_SETTLE_INIT;
    end else if (r_settle != '0) begin
      r_settle <= r_settle - SW'(1);
    end
  end

  assign idx         = r_idx;
  assign settle_done = (r_settle == '0);
  assign last        = (r_idx == {N_IN{1'b1}});

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// truth_table_sweeper : sweeps all inputs of a combinational function and
//                       checks the sampled truth table against an expected one
// Rev 1.0
// ============================================================================
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [tt_bits(N_IN)-1:0]     exp_tt,
  output logic [N_IN-1:0]              f_in,
  input  logic                         f_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [cnt_bits(N_IN)-1:0]    err_cnt,
  output logic                         first_err_vld,
  output logic [N_IN-1:0]              first_err_idx,
  output logic [tt_bits(N_IN)-1:0]     cap_tt
);

  localparam int TT_W  = tt_bits(N_IN);
  localparam int CNT_W = cnt_bits(N_IN);

  sweep_state_t      r_state;
  sweep_state_t      w_state_nxt;
  logic [TT_W-1:0]   r_exp_q;
  logic [TT_W-1:0]   r_cap_tt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_first_vld;
  logic [N_IN-1:0]   r_first_idx;
  logic              r_pass;

  logic [N_IN-1:0]   w_idx;
  logic              w_settle_done;
  logic              w_last;
  logic              w_start_acc;
  logic              w_sample;
  logic              w_mismatch;
  logic [CNT_W-1:0]  w_err_nxt;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_sample    = (r_state == ST_SAMPLE);
  assign w_mismatch  = (f_out != r_exp_q[w_idx]);
  assign w_err_nxt   = r_err_cnt + CNT_W'(w_mismatch);

  truth_table_sweeper_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_start_acc),
    .step        (w_sample && !w_last),
    .idx         (w_idx),
    .settle_done (w_settle_done),
    .last        (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  if (w_settle_done) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // pass is resolved on the final sample so it is already valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_q     <= '0;
      r_cap_tt    <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_pass      <= 1'b0;
    end else if (w_start_acc) begin
      r_exp_q     <= exp_tt;
      r_cap_tt    <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_pass      <= 1'b0;
    end else if (w_sample) begin
      r_cap_tt[w_idx] <= f_out;
      if (w_mismatch) begin
        r_err_cnt <= w_err_nxt;
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= w_idx;
        end
      end
      if (w_last) begin
        r_pass <= (w_err_nxt == '0);
      end
    end
  end

  assign f_in          = w_idx;
  assign busy          = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  assign done          = (r_state == ST_DONE);
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign first_err_vld = r_first_vld;
  assign first_err_idx = r_first_idx;
  assign cap_tt        = r_cap_tt;

endmodule
`default_nettype wire
